// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared state encoding, access-size and byte-enable constants for the load/store unit
package lsu_pkg;

    // FSM state encoding, kept as plain constants so the controller can decode it too
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // func3 access size / signedness
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // store byte-enable patterns produced by the controller
    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_SB   = 4'b0001;
    localparam logic [3:0] BE_SH   = 4'b0011;
    localparam logic [3:0] BE_SW   = 4'b1111;

    // size is func3[1:0]: 00 byte, 01 half, anything else is treated as a word
    function automatic logic lsu_misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            2'b00:   return 1'b0;
            2'b01:   return lane[0];
            default: return (lane != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - memory bus between the load/store unit (master) and data memory (slave)
// bus_req/bus_we/bus_addr/bus_wdata : request from master; bus_we == 0 means read
// bus_gnt                           : slave accepted the request this cycle
// bus_rvalid/bus_rdata              : read data returned by the slave
interface load_store_unit_if #(parameter int ADDR_W = 32);
    logic              bus_req;
    logic [3:0]        bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [31:0]       bus_wdata;
    logic              bus_gnt;
    logic              bus_rvalid;
    logic [31:0]       bus_rdata;

    modport master (
        output bus_req, bus_we, bus_addr, bus_wdata,
        input  bus_gnt, bus_rvalid, bus_rdata
    );

    modport slave (
        input  bus_req, bus_we, bus_addr, bus_wdata,
        output bus_gnt, bus_rvalid, bus_rdata
    );
endinterface

// File: rtl/load_store_unit_load_extend.sv
// rtl/load_store_unit_load_extend.sv - selects byte/halfword from a read word and extends it
// rdata  : raw read word from the bus
// lane   : byte offset addr[1:0] of the access
// func3  : access size and signedness
// result : extended 32-bit load value
module load_extend
    import lsu_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  lane,
    input  logic [2:0]  func3,
    output logic [31:0] result
);
    logic [31:0] shifted;

    always_comb begin
        // bring the addressed byte/halfword down to bit 0
        shifted = rdata >> {lane, 3'b000};
        case (func3)
            F3_B:    result = {{24{shifted[7]}}, shifted[7:0]};
            F3_H:    result = {{16{shifted[15]}}, shifted[15:0]};
            F3_BU:   result = {24'd0, shifted[7:0]};
            F3_HU:   result = {16'd0, shifted[15:0]};
            default: result = rdata;
        endcase
    end
endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit with stall and misalignment detection
// clk, rst        : clock, asynchronous active-high reset
// ld_en, dm_w_en  : load request / store byte enables (store wins when both set)
// func3, addr     : access size/sign and effective address
// st_data         : store data
// bus             : memory bus master port
// ld_data_f       : extended load result, held until the next load completes
// stall           : hold PC and register-file write
// misalign_err    : current access is misaligned and was suppressed
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ld_en,
    input  logic [3:0]                dm_w_en,
    input  logic [2:0]                func3,
    input  logic [ADDR_W-1:0]         addr,
    input  logic [31:0]               st_data,
    load_store_unit_if.master         bus,
    output logic [31:0]               ld_data_f,
    output logic                      stall,
    output logic                      misalign_err
);
    logic [1:0]  state;
    logic        is_store;
    logic        pending;
    logic        misaligned;
    logic        start;
    logic [3:0]  we_shifted;
    logic [31:0] wdata_lanes;
    logic        lat_load;
    logic [1:0]  lat_lane;
    logic [2:0]  lat_func3;
    logic [31:0] ld_ext;

    assign is_store   = (dm_w_en != BE_NONE);
    assign pending    = is_store || ld_en;
    assign misaligned = lsu_misaligned(func3[1:0], addr[1:0]);
    assign start      = pending && !misaligned;
    assign we_shifted = dm_w_en << addr[1:0];

    // narrow stores are replicated across lanes so the strobes alone pick the target bytes
    always_comb begin
        case (dm_w_en)
            BE_SB:   wdata_lanes = {4{st_data[7:0]}};
            BE_SH:   wdata_lanes = {2{st_data[15:0]}};
            default: wdata_lanes = st_data;
        endcase
    end

    always_comb begin
        stall = 1'b0;
        case (state)
            ST_IDLE: stall = start;
            ST_REQ:  stall = 1'b1;
            ST_WAIT: stall = 1'b1;
            default: stall = 1'b0;
        endcase
    end

    assign misalign_err = (state == ST_IDLE) && pending && misaligned;
    // decoded from state so reset drops the request without a clock edge
    assign bus.bus_req  = (state == ST_REQ);

    // extraction uses the lane/size latched at request time, not the live inputs
    load_extend u_load_extend (
        .rdata  (bus.bus_rdata),
        .lane   (lat_lane),
        .func3  (lat_func3),
        .result (ld_ext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            bus.bus_we    <= 4'b0000;
            bus.bus_addr  <= '0;
            bus.bus_wdata <= 32'd0;
            ld_data_f     <= 32'd0;
            lat_load      <= 1'b0;
            lat_lane      <= 2'b00;
            lat_func3     <= 3'b000;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        bus.bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
                        bus.bus_we    <= we_shifted;
                        bus.bus_wdata <= wdata_lanes;
                        lat_load      <= !is_store;
                        lat_lane      <= addr[1:0];
                        lat_func3     <= func3;
                        state         <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (bus.bus_gnt) begin
                        if (!lat_load) begin
                            state <= ST_DONE;
                        end else if (bus.bus_rvalid) begin
                            ld_data_f <= ld_ext;
                            state     <= ST_DONE;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (bus.bus_rvalid) begin
                        ld_data_f <= ld_ext;
                        state     <= ST_DONE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with a behavioural reference model
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        ld_en;
    logic [3:0]  dm_w_en;
    logic [2:0]  func3;
    logic [31:0] addr;
    logic [31:0] st_data;
    logic [31:0] ld_data_f;
    logic        stall;
    logic        misalign_err;

    always #5 clk = ~clk;

    load_store_unit_if #(.ADDR_W(32)) bus_if ();

    load_store_unit #(.ADDR_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .ld_en        (ld_en),
        .dm_w_en      (dm_w_en),
        .func3        (func3),
        .addr         (addr),
        .st_data      (st_data),
        .bus          (bus_if),
        .ld_data_f    (ld_data_f),
        .stall        (stall),
        .misalign_err (misalign_err)
    );

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  we;
        logic [31:0] wdata;
        bit          chk_wdata;
    } req_t;

    typedef struct {
        int          stalls;
        logic [31:0] ld;
    } done_t;

    req_t        exp_req[$];
    done_t       exp_done[$];
    int          checks = 0;
    int          passes = 0;
    bit          mon_en = 1'b0;
    logic [31:0] last_ld = 32'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    endtask

    function automatic logic [31:0] ld_model(input logic [31:0] rd, input logic [1:0] lane,
                                             input logic [2:0] f3);
        logic [31:0] w;
        w = rd >> (8 * lane);
        case (f3)
            3'b000:  return 32'($signed(w[7:0]));
            3'b001:  return 32'($signed(w[15:0]));
            3'b100:  return w & 32'h0000_00FF;
            3'b101:  return w & 32'h0000_FFFF;
            default: return rd;
        endcase
    endfunction

    // Monitor: compares accepted bus requests and completed transactions
    initial begin
        int    cnt;
        req_t  er;
        done_t ed;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (!mon_en || rst) begin
                cnt = 0;
            end else begin
                if (misalign_err) check("bus_req_on_misalign", {31'd0, bus_if.bus_req}, 32'd0);
                if (bus_if.bus_req && bus_if.bus_gnt) begin
                    if (exp_req.size() == 0) begin
                        check("unexpected_req", 32'd1, 32'd0);
                    end else begin
                        er = exp_req.pop_front();
                        check("bus_addr", bus_if.bus_addr, er.addr);
                        check("bus_we", {28'd0, bus_if.bus_we}, {28'd0, er.we});
                        if (er.chk_wdata) check("bus_wdata", bus_if.bus_wdata, er.wdata);
                    end
                end
                if (stall) begin
                    cnt++;
                end else if (cnt > 0) begin
                    if (exp_done.size() == 0) begin
                        check("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        ed = exp_done.pop_front();
                        check("stall_cycles", cnt, ed.stalls);
                        check("ld_data_f", ld_data_f, ed.ld);
                    end
                    cnt = 0;
                end
            end
        end
    end

    // Called at posedge+1 with the DUT idle; returns at posedge+1 with the DUT idle again.
    task automatic do_txn(input logic ld, input logic [3:0] we, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                          input int g, input int r);
        bit    store;
        bit    mis;
        int    w;
        req_t  er;
        done_t ed;
        store = (we != 4'b0000);
        case (f3[1:0])
            2'b00:   mis = 1'b0;
            2'b01:   mis = a[0];
            default: mis = (a[1:0] != 2'b00);
        endcase
        ld_en = ld; dm_w_en = we; func3 = f3; addr = a; st_data = sd;
        bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0; bus_if.bus_rdata = $urandom;
        if (!store && !ld) begin
            @(posedge clk); #1;
            return;
        end
        if (mis) begin
            #1;
            check("misalign_err", {31'd0, misalign_err}, 32'd1);
            check("misalign_stall", {31'd0, stall}, 32'd0);
            @(posedge clk); #1;
            check("misalign_no_req", {31'd0, bus_if.bus_req}, 32'd0);
            check("misalign_ld_hold", ld_data_f, last_ld);
            ld_en = 1'b0; dm_w_en = 4'b0000;
            return;
        end
        w = (int'(we) << a[1:0]) & 15;
        er.addr = a & 32'hFFFF_FFFC;
        er.we = w[3:0];
        er.chk_wdata = store;
        if (we == 4'b0001)      er.wdata = {24'd0, sd[7:0]} * 32'h0101_0101;
        else if (we == 4'b0011) er.wdata = {16'd0, sd[15:0]} * 32'h0001_0001;
        else                    er.wdata = sd;
        ed.stalls = 2 + g + (store ? 0 : r);
        if (!store) last_ld = ld_model(rd, a[1:0], f3);
        ed.ld = last_ld;
        exp_req.push_back(er);
        exp_done.push_back(ed);
        @(posedge clk); #1;
        for (int i = 0; i < g; i++) begin
            bus_if.bus_gnt = 1'b0;
            bus_if.bus_rvalid = 1'($urandom % 2);
            bus_if.bus_rdata = $urandom;
            @(posedge clk); #1;
        end
        bus_if.bus_gnt = 1'b1;
        if (store) begin
            bus_if.bus_rvalid = 1'($urandom % 2);
            bus_if.bus_rdata = $urandom;
        end else begin
            bus_if.bus_rvalid = (r == 0);
            bus_if.bus_rdata = (r == 0) ? rd : $urandom;
        end
        @(posedge clk); #1;
        bus_if.bus_gnt = 1'b0;
        if (!store && r > 0) begin
            for (int i = 0; i < r - 1; i++) begin
                bus_if.bus_rvalid = 1'b0;
                bus_if.bus_rdata = $urandom;
                @(posedge clk); #1;
            end
            bus_if.bus_rvalid = 1'b1;
            bus_if.bus_rdata = rd;
            @(posedge clk); #1;
        end
        bus_if.bus_rvalid = 1'($urandom % 2);
        bus_if.bus_rdata = $urandom;
        @(posedge clk); #1;
        ld_en = 1'b0; dm_w_en = 4'b0000; bus_if.bus_rvalid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ld_en = 1'b0; dm_w_en = 4'b0000; func3 = 3'b000;
        addr = 32'd0; st_data = 32'd0;
        bus_if.bus_gnt = 1'b0; bus_if.bus_rvalid = 1'b0; bus_if.bus_rdata = 32'd0;
        #2;
        check("rst_bus_req", {31'd0, bus_if.bus_req}, 32'd0);
        check("rst_bus_we", {28'd0, bus_if.bus_we}, 32'd0);
        check("rst_bus_addr", bus_if.bus_addr, 32'd0);
        check("rst_bus_wdata", bus_if.bus_wdata, 32'd0);
        check("rst_ld_data_f", ld_data_f, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // reset while a load is waiting for data
        ld_en = 1'b1; func3 = 3'b010; addr = 32'h200;
        @(posedge clk); #1;
        check("req_asserted", {31'd0, bus_if.bus_req}, 32'd1);
        bus_if.bus_gnt = 1'b1;
        @(posedge clk); #1;
        bus_if.bus_gnt = 1'b0;
        check("wait_stall", {31'd0, stall}, 32'd1);
        #1 rst = 1'b1; ld_en = 1'b0;
        #1;
        check("rst_async_stall", {31'd0, stall}, 32'd0);
        check("rst_async_req", {31'd0, bus_if.bus_req}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;
        bus_if.bus_rvalid = 1'b1; bus_if.bus_rdata = 32'hCAFE_F00D;
        repeat (2) @(posedge clk);
        #1;
        check("late_rvalid_ignored", ld_data_f, 32'd0);
        check("late_rvalid_stall", {31'd0, stall}, 32'd0);
        bus_if.bus_rvalid = 1'b0;
        @(posedge clk); #1;

        mon_en = 1'b1;
        do_txn(1'b0, 4'b1111, 3'b010, 32'h104, 32'hDEAD_BEEF, 32'd0, 0, 0);
        do_txn(1'b0, 4'b0001, 3'b000, 32'h103, 32'h0000_00A5, 32'd0, 0, 0);
        do_txn(1'b1, 4'b0000, 3'b000, 32'h102, 32'd0, 32'h1280_5634, 1, 1);
        check("lb_result", ld_data_f, 32'hFFFF_FF80);
        do_txn(1'b1, 4'b0000, 3'b101, 32'h102, 32'd0, 32'h8001_5634, 0, 0);
        check("lhu_result", ld_data_f, 32'h0000_8001);
        do_txn(1'b1, 4'b0000, 3'b001, 32'h102, 32'd0, 32'h8001_5634, 0, 2);
        check("lh_result", ld_data_f, 32'hFFFF_8001);
        do_txn(1'b1, 4'b0000, 3'b010, 32'h101, 32'd0, 32'h1111_1111, 0, 0);
        do_txn(1'b1, 4'b0011, 3'b001, 32'h202, 32'h1234_BEEF, 32'h5555_5555, 2, 0);
        check("store_wins_ld_hold", ld_data_f, 32'hFFFF_8001);

        for (int n = 0; n < 150; n++) begin
            int          kind;
            logic [2:0]  f3;
            logic [3:0]  we;
            logic        ld;
            kind = int'($urandom % 8);
            ld = 1'b1;
            we = 4'b0000;
            case (kind)
                0: begin we = 4'b0001; f3 = 3'b000; ld = 1'($urandom % 2); end
                1: begin we = 4'b0011; f3 = 3'b001; ld = 1'($urandom % 2); end
                2: begin we = 4'b1111; f3 = 3'b010; ld = 1'($urandom % 2); end
                3: f3 = 3'b000;
                4: f3 = 3'b001;
                5: f3 = 3'b010;
                6: f3 = 3'b100;
                default: f3 = 3'b101;
            endcase
            do_txn(ld, we, f3, $urandom, $urandom, $urandom,
                   int'($urandom % 4), int'($urandom % 4));
        end

        repeat (3) @(posedge clk);
        #1;
        check("req_queue_drained", exp_req.size(), 32'd0);
        check("done_queue_drained", exp_done.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
